// File: rtl/vend_pkg.sv
// Shared state encoding, coin values and item pricing for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam int unsigned QUARTER_C = 25;
  localparam int unsigned DIME_C    = 10;
  localparam int unsigned NICKEL_C  = 5;

  function automatic int unsigned price(input int unsigned idx,
                                        input int unsigned base,
                                        input int unsigned step);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/vend_fsm_ctrl_change_maker.sv
// Greedy change dispenser: removes one coin from the credit per enabled cycle
// and keeps saturating 4-bit counts of the coins returned.
module change_maker
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [CREDIT_W-1:0] o_credit_nxt,
  output logic [3:0]          o_quarters,
  output logic [3:0]          o_dimes,
  output logic [3:0]          o_nickels
);

  logic [CREDIT_W-1:0] w_coin;
  logic [1:0]          w_sel;
  logic [3:0]          r_quarters;
  logic [3:0]          r_dimes;
  logic [3:0]          r_nickels;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    w_coin = CREDIT_W'(NICKEL_C);
    w_sel  = 2'd2;
    if (i_credit >= CREDIT_W'(QUARTER_C)) begin
      w_coin = CREDIT_W'(QUARTER_C);
      w_sel  = 2'd0;
    end else if (i_credit >= CREDIT_W'(DIME_C)) begin
      w_coin = CREDIT_W'(DIME_C);
      w_sel  = 2'd1;
    end
  end

  assign o_credit_nxt = i_credit - w_coin;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_quarters <= '0;
      r_dimes    <= '0;
      r_nickels  <= '0;
    end else if (i_en) begin
      case (w_sel)
        2'd0:    r_quarters <= sat_inc(r_quarters);
        2'd1:    r_dimes    <= sat_inc(r_dimes);
        default: r_nickels  <= sat_inc(r_nickels);
      endcase
    end
  end

  assign o_quarters = r_quarters;
  assign o_dimes    = r_dimes;
  assign o_nickels  = r_nickels;

endmodule

// File: rtl/vend_fsm_ctrl.sv
// Vending controller: coin edge detection, bounded credit, item vend and greedy change.
// Define AUTO_CHANGE_EN to return leftover credit automatically after each vend.
module vend_fsm_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = 4,
  parameter int BASE_PRICE  = 25,
  parameter int PRICE_STEP  = 10,
  parameter int MAX_CREDIT  = 95,
  parameter int CREDIT_W    = 7,
  parameter int VEND_CYCLES = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Quarters,
  input  logic                 Dimes,
  input  logic                 Nickles,
  input  logic [NUM_ITEMS-1:0] Buy,
  input  logic                 Refund,
  output logic [NUM_ITEMS-1:0] Vending,
  output logic [CREDIT_W-1:0]  Credit,
  output logic                 Busy,
  output logic                 Reject,
  output logic                 ChangeDone,
  output logic [3:0]           QuarterOut,
  output logic [3:0]           DimeOut,
  output logic [3:0]           NickelOut
);

  localparam int PW    = CREDIT_W + 1;
  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CREDIT_W-1:0]  r_credit;
  logic [CREDIT_W-1:0]  w_credit_nxt;
  logic [NUM_ITEMS-1:0] r_vending;
  logic [NUM_ITEMS-1:0] w_vending_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_reject;
  logic                 w_reject_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_q_prev;
  logic                 r_d_prev;
  logic                 r_n_prev;
  logic                 w_q_edge;
  logic                 w_d_edge;
  logic                 w_n_edge;
  logic                 w_coin_any;
  logic [PW-1:0]        w_sum;
  logic [PW-1:0]        w_total;
  logic [PW-1:0]        w_base;
  logic [PW-1:0]        w_price;
  logic                 w_chg_clr;
  logic                 w_chg_en;
  logic [CREDIT_W-1:0]  w_chg_credit;

  assign w_q_edge   = Quarters & ~r_q_prev;
  assign w_d_edge   = Dimes    & ~r_d_prev;
  assign w_n_edge   = Nickles  & ~r_n_prev;
  assign w_coin_any = w_q_edge | w_d_edge | w_n_edge;

  assign w_sum   = (w_q_edge ? PW'(QUARTER_C) : '0)
                 + (w_d_edge ? PW'(DIME_C)    : '0)
                 + (w_n_edge ? PW'(NICKEL_C)  : '0);
  assign w_total = {1'b0, r_credit} + w_sum;

  always_comb begin
    w_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (Buy[i]) w_price = PW'(price(i, BASE_PRICE, PRICE_STEP));
    end
  end

  // Coins are folded into the credit before the price compare so a last coin can complete a purchase.
  always_comb begin
    w_state_nxt   = r_state;
    w_credit_nxt  = r_credit;
    w_vending_nxt = r_vending;
    w_cnt_nxt     = r_cnt;
    w_reject_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
    w_chg_clr     = 1'b0;
    w_base        = {1'b0, r_credit};
    case (r_state)
      IDLE: begin
        if (w_coin_any) begin
          if (w_total <= PW'(MAX_CREDIT)) w_base = w_total;
          else                            w_reject_nxt = 1'b1;
        end
        w_credit_nxt = CREDIT_W'(w_base);
        if ($onehot(Buy)) begin
          if (w_base >= w_price) begin
            w_credit_nxt  = CREDIT_W'(w_base - w_price);
            w_state_nxt   = VEND;
            w_vending_nxt = Buy;
            w_cnt_nxt     = CNT_W'(VEND_CYCLES - 1);
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else if (Refund && (w_base != '0)) begin
          w_state_nxt = CHANGE;
          w_chg_clr   = 1'b1;
        end
      end
      VEND: begin
        w_reject_nxt = w_coin_any;
        if (r_cnt == '0) begin
          w_vending_nxt = '0;
`ifdef AUTO_CHANGE_EN
          if (r_credit != '0) begin
            w_state_nxt = CHANGE;
            w_chg_clr   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
`else
          w_state_nxt = IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      CHANGE: begin
        w_reject_nxt = w_coin_any;
        if (r_credit == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_credit_nxt = w_chg_credit;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge registers reset high so a coin input held through reset is not counted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_credit  <= '0;
      r_vending <= '0;
      r_cnt     <= '0;
      r_reject  <= 1'b0;
      r_done    <= 1'b0;
      r_q_prev  <= 1'b1;
      r_d_prev  <= 1'b1;
      r_n_prev  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_credit  <= w_credit_nxt;
      r_vending <= w_vending_nxt;
      r_cnt     <= w_cnt_nxt;
      r_reject  <= w_reject_nxt;
      r_done    <= w_done_nxt;
      r_q_prev  <= Quarters;
      r_d_prev  <= Dimes;
      r_n_prev  <= Nickles;
    end
  end

  assign w_chg_en = (r_state == CHANGE) && (r_credit != '0);

  change_maker #(
    .CREDIT_W(CREDIT_W)
  ) u_change_maker (
    .i_clk        (Clock),
    .i_rst        (Reset),
    .i_en         (w_chg_en),
    .i_clr        (w_chg_clr),
    .i_credit     (r_credit),
    .o_credit_nxt (w_chg_credit),
    .o_quarters   (QuarterOut),
    .o_dimes      (DimeOut),
    .o_nickels    (NickelOut)
  );

  assign Vending    = r_vending;
  assign Credit     = r_credit;
  assign Busy       = (r_state != IDLE);
  assign Reject     = r_reject;
  assign ChangeDone = r_done;

endmodule

// File: tb/tb_vend_fsm_ctrl.sv
// Scoreboard bench for vend_fsm_ctrl: each row queues stimulus with the outputs expected after that edge.
module tb_vend_fsm_ctrl;

  localparam int NI = 4;
  localparam int CW = 7;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Quarters;
  logic          Dimes;
  logic          Nickles;
  logic [NI-1:0] Buy;
  logic          Refund;
  logic [NI-1:0] Vending;
  logic [CW-1:0] Credit;
  logic          Busy;
  logic          Reject;
  logic          ChangeDone;
  logic [3:0]    QuarterOut;
  logic [3:0]    DimeOut;
  logic [3:0]    NickelOut;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]  st_q[$];
  logic [25:0] sb_q[$];

  always #5 Clock = ~Clock;

  vend_fsm_ctrl #(
    .NUM_ITEMS(NI), .BASE_PRICE(25), .PRICE_STEP(10),
    .MAX_CREDIT(95), .CREDIT_W(CW), .VEND_CYCLES(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Quarters(Quarters), .Dimes(Dimes),
    .Nickles(Nickles), .Buy(Buy), .Refund(Refund), .Vending(Vending),
    .Credit(Credit), .Busy(Busy), .Reject(Reject), .ChangeDone(ChangeDone),
    .QuarterOut(QuarterOut), .DimeOut(DimeOut), .NickelOut(NickelOut)
  );

  function automatic logic [8:0] S(logic r, logic q, logic d, logic n, logic [3:0] b, logic f);
    return {r, q, d, n, b, f};
  endfunction

  function automatic logic [25:0] E(int c, logic rj, logic [3:0] v, logic bz, logic dn,
                                    int qo, int dq, int nq);
    return {7'(c), rj, v, bz, dn, 4'(qo), 4'(dq), 4'(nq)};
  endfunction

  function automatic logic [25:0] obs();
    return {Credit, Reject, Vending, Busy, ChangeDone, QuarterOut, DimeOut, NickelOut};
  endfunction

  task automatic put(logic [8:0] s, logic [25:0] e);
    st_q.push_back(s);
    sb_q.push_back(e);
  endtask

  task automatic drive(logic [8:0] s);
    {Reset, Quarters, Dimes, Nickles, Buy, Refund} = s;
  endtask

  task automatic test_reset();
    put(S(1,1,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,0));
    put(S(0,1,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,0));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,0));
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL reset[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  task automatic test_coins();
    put(S(0,1,0,0,4'b0000,0), E(25,0,4'b0000,0,0,0,0,0));
    put(S(0,0,1,0,4'b0000,0), E(35,0,4'b0000,0,0,0,0,0));
    put(S(0,0,0,1,4'b0000,0), E(40,0,4'b0000,0,0,0,0,0));
    put(S(0,0,0,0,4'b0000,0), E(40,0,4'b0000,0,0,0,0,0));
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL coins[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  task automatic test_vend();
    put(S(0,0,0,0,4'b0010,0), E(5,0,4'b0010,1,0,0,0,0));
    put(S(0,0,1,0,4'b0000,0), E(5,1,4'b0010,1,0,0,0,0));
    put(S(0,0,0,0,4'b0000,0), E(5,0,4'b0010,1,0,0,0,0));
    put(S(0,0,0,0,4'b0000,0), E(5,0,4'b0010,1,0,0,0,0));
`ifdef AUTO_CHANGE_EN
    put(S(0,0,0,0,4'b0000,0), E(5,0,4'b0000,1,0,0,0,0));
    put(S(0,0,0,0,4'b0000,1), E(0,0,4'b0000,1,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,1,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,1));
`else
    put(S(0,0,0,0,4'b0000,0), E(5,0,4'b0000,0,0,0,0,0));
    put(S(0,0,0,0,4'b0000,1), E(5,0,4'b0000,1,0,0,0,0));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,1,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,1,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,1));
`endif
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL vend[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  task automatic test_buy_reject();
    put(S(0,0,1,0,4'b0000,0), E(10,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(10,0,4'b0000,0,0,0,0,1));
    put(S(0,0,1,0,4'b0000,0), E(20,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0001,0), E(20,1,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0011,0), E(20,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,1,4'b0001,1), E(0,0,4'b0001,1,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0001,1,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0001,1,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0001,1,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,1));
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL buy_reject[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  task automatic test_overflow();
    put(S(0,1,1,1,4'b0000,0), E(40,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(40,0,4'b0000,0,0,0,0,1));
    put(S(0,1,1,1,4'b0000,0), E(80,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(80,0,4'b0000,0,0,0,0,1));
    put(S(0,0,1,0,4'b0000,0), E(90,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(90,0,4'b0000,0,0,0,0,1));
    put(S(0,0,1,0,4'b0000,0), E(90,1,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(90,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,1,4'b0000,0), E(95,0,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(95,0,4'b0000,0,0,0,0,1));
    put(S(0,1,0,0,4'b0000,0), E(95,1,4'b0000,0,0,0,0,1));
    put(S(0,0,0,0,4'b0000,0), E(95,0,4'b0000,0,0,0,0,1));
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL overflow[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  task automatic test_refund();
    put(S(0,0,0,0,4'b0000,1), E(95,0,4'b0000,1,0,0,0,0));
    put(S(0,1,0,0,4'b0000,0), E(70,1,4'b0000,1,0,1,0,0));
    put(S(0,0,0,0,4'b0000,0), E(45,0,4'b0000,1,0,2,0,0));
    put(S(0,0,0,0,4'b0000,0), E(20,0,4'b0000,1,0,3,0,0));
    put(S(0,0,0,0,4'b0000,0), E(10,0,4'b0000,1,0,3,1,0));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,1,0,3,2,0));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,1,3,2,0));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,3,2,0));
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL refund[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_vend();
    put(S(0,1,0,0,4'b0000,0), E(25,0,4'b0000,0,0,3,2,0));
    put(S(0,0,0,0,4'b0000,0), E(25,0,4'b0000,0,0,3,2,0));
    put(S(0,1,0,0,4'b0000,0), E(50,0,4'b0000,0,0,3,2,0));
    put(S(0,0,0,0,4'b0001,0), E(25,0,4'b0001,1,0,3,2,0));
    put(S(0,0,0,0,4'b0000,0), E(25,0,4'b0001,1,0,3,2,0));
    put(S(1,1,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,0));
    put(S(0,1,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,0));
    put(S(0,0,0,0,4'b0000,0), E(0,0,4'b0000,0,0,0,0,0));
    for (int i = 0; st_q.size() > 0; i++) begin
      logic [25:0] got, want;
      drive(st_q.pop_front());
      @(posedge Clock); #1;
      got = obs(); want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_errors++;
        $display("FAIL reset_mid_vend[%0d]: got %h want %h (credit,rej,vend,busy,done,q,d,n)", i, got, want);
      end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    Quarters = 1'b1;
    Dimes    = 1'b0;
    Nickles  = 1'b0;
    Buy      = '0;
    Refund   = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    test_reset();
    test_coins();
    test_vend();
    test_buy_reject();
    test_overflow();
    test_refund();
    test_reset_mid_vend();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vend_fsm_ctrl.md
Name: vend_fsm_ctrl

Overview:
Parametrised vending controller. Accepts edge-detected coin inputs, keeps a bounded credit, and vends one of NUM_ITEMS items. Returns change greedily, one coin per cycle, and reports how many coins of each type were returned. It sits between the coin/button inputs and the seven-segment display drivers, and replaces the separate counter/sum/buy/refund blocks with a single state machine.

Parameters:
NUM_ITEMS, 4, number of selectable items (1..8)
BASE_PRICE, 25, price of item 0 in cents (multiple of 5)
PRICE_STEP, 10, price increment per item index; item i costs BASE_PRICE + i*PRICE_STEP (multiple of 5)
MAX_CREDIT, 95, highest credit accepted, in cents (multiple of 5, must be below 2**CREDIT_W)
CREDIT_W, 7, width of the credit register
VEND_CYCLES, 4, number of cycles the Vending bit is held high

Ports:
Clock  in  1  single clock
Reset  in  1  synchronous, active-high reset
Quarters  in  1  level input; each rising edge is one 25c coin
Dimes  in  1  level input; each rising edge is one 10c coin
Nickles  in  1  level input; each rising edge is one 5c coin
Buy  in  NUM_ITEMS  item select; valid only when exactly one bit is set
Refund  in  1  request to return all credit
Vending  out  NUM_ITEMS  one-hot, high while an item is dispensed
Credit  out  CREDIT_W  current credit in cents
Busy  out  1  high in VEND or CHANGE
Reject  out  1  one-cycle pulse when a coin or a buy request is refused
ChangeDone  out  1  one-cycle pulse when change return finishes
QuarterOut  out  4  quarters returned in the last change sequence
DimeOut  out  4  dimes returned in the last change sequence
NickelOut  out  4  nickels returned in the last change sequence

Behaviour:
- Reset: state IDLE. Credit, Vending, Reject, ChangeDone and all *Out counts are 0. Coin edge-detect registers reset to 1, so an input held high through reset is not counted.
- Coin detection: rising edge = input high while its previous-cycle register is low. Edges arriving in the same cycle are summed.
- IDLE, coin accept: if Credit + sum <= MAX_CREDIT, Credit updates on the next edge (1-cycle latency). Otherwise every coin in that cycle is refused, Reject pulses, and Credit is unchanged.
- VEND/CHANGE, coin accept: all coin edges are refused and Reject pulses.
- IDLE, Buy:
  - not one-hot (zero or several bits set): ignored, no Reject.
  - one-hot, item i, Credit >= price(i): Credit -= price(i); go to VEND; Vending[i] is high for exactly VEND_CYCLES cycles starting next cycle.
  - one-hot, Credit < price(i): Reject pulses, no state change.
- Buy and coin in the same cycle: the coin is added first, then the price is compared against the new total.
- Buy and Refund in the same cycle: Buy wins; Refund is dropped.
- IDLE, Refund: Credit > 0 goes to CHANGE; Credit == 0 is ignored.
- Entering CHANGE: all *Out counts clear on the entry cycle.
- CHANGE, one coin per cycle:
  - Credit >= 25: QuarterOut++, Credit -= 25
  - else Credit >= 10: DimeOut++, Credit -= 10
  - else: NickelOut++, Credit -= 5
  - Counts saturate at 15.
- CHANGE exit: the cycle after Credit reaches 0, ChangeDone pulses and the state returns to IDLE. The *Out counts hold until the next CHANGE entry.
- VEND end: after the VEND_CYCLES countdown expires, Vending clears, then behaviour depends on the Optional Feature.
- Reset mid-VEND or mid-CHANGE: return to IDLE and lose the credit (no refund).
- Busy is driven by the registered state.
- Arithmetic: all arithmetic is unsigned, CREDIT_W+1 bits wide for the overflow compare. Credit is always a multiple of 5, so CHANGE always terminates.

Optional Feature:
AUTO_CHANGE_EN
- Defined: after VEND, any Credit > 0 goes directly to CHANGE; Credit == 0 goes to IDLE.
- Undefined: after VEND the state always returns to IDLE with the remaining credit kept for further purchases or a later Refund.

Decomposition:
- Shared package vend_pkg holds:
  - state enum {IDLE, VEND, CHANGE}
  - coin values QUARTER_C=25, DIME_C=10, NICKEL_C=5
  - a price function taking the item index.
- One sub-module, change_maker: greedy one-coin-per-cycle subtractor with saturating counts, enabled by the CHANGE state.

Test Plan:
- Quarter, Dime, Nickel edges on separate cycles -> Credit = 25, 35, 40; no Reject.
- Credit 90, Dime edge -> Reject pulse; Credit stays 90. Credit 90, Nickel edge -> Credit 95.
- Credit 40, Buy=4'b0010 (price 35) -> Vending=4'b0010 for 4 cycles; Credit 5. With AUTO_CHANGE_EN: NickelOut=1, ChangeDone. Without: IDLE, Credit 5.
- Credit 20, Buy=4'b0001 -> Reject, Credit 20. Buy=4'b0011 -> ignored, no Reject.
- Credit 90, Refund -> 3 quarters, 1 dime, 1 nickel over 5 cycles (Quarter/Dime/NickelOut=3/1/1), ChangeDone, Credit 0.
- Reset asserted on the 2nd VEND cycle -> next cycle IDLE, Vending=0, Credit=0. Quarters held high across reset -> no credit added.
